// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the round-robin demux scheduler.
// Fixed 8-way geometry: 3-bit select and 4-bit hold/gap counters.
package demux_sched_pkg;

  localparam int N_OUT = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Rotate right by ptr, priority-encode the lowest bit, then add ptr back mod 8.
module rr_pick8
  import demux_sched_pkg::*;
(
  input  logic [N_OUT-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N_OUT-1:0] rot;
  logic [SEL_W-1:0] off;

  assign rot = N_OUT'({req, req} >> ptr);

  always_comb begin
    // NOTE: give every always_comb output a value before any branch, otherwise a latch is inferred.
    off = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = off + ptr;
    any = |req;
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler driving the select/enable of a 1-to-8 demux.
// Grants last up to HOLD_CYCLES, separated by GAP_CYCLES idle cycles.
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_OUT-1:0] req,
  output logic [SEL_W-1:0] S,
  output logic             D,
  output logic [N_OUT-1:0] gnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] gap_cnt;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             start;
  logic             release_now;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign start       = en & pick_any;
  // HOLD_CYCLES == 0 means the grant only ends when its request drops.
  assign release_now = !req[S] || ((HOLD_CYCLES != 0) && (hold_cnt == HOLD_LAST));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      S        <= '0;
      D        <= 1'b0;
      gnt      <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= GRANT;
            S        <= pick_idx;
            D        <= 1'b1;
            gnt      <= N_OUT'(1) << pick_idx;
            hold_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        GRANT: begin
          hold_cnt <= hold_cnt + CNT_W'(1);
          if (release_now) begin
            state   <= GAP;
            D       <= 1'b0;
            gnt     <= '0;
            ptr     <= S + SEL_W'(1);
            gap_cnt <= '0;
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt + CNT_W'(1);
          if (gap_cnt == GAP_LAST) begin
            if (start) begin
              state    <= GRANT;
              S        <= pick_idx;
              D        <= 1'b1;
              gnt      <= N_OUT'(1) << pick_idx;
              hold_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Self-checking bench for demux_rr_sched: vector tables, directed corner sequences,
// and randomized traffic compared against a cycle-level behavioural model.
module tb_demux_rr_sched;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] req = 8'h00;
  logic [2:0] S;
  logic       D;
  logic [7:0] gnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  demux_rr_sched #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .S     (S),
    .D     (D),
    .gnt   (gnt),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one sink is either being served, the bus is resting, or nothing happens.
  int m_active, m_cur, m_ptr, m_held, m_gap_left;

  task automatic model_reset();
    m_active = 0; m_cur = 0; m_ptr = 0; m_held = 0; m_gap_left = 0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r);
    int may_pick;
    int found;
    if (m_active != 0) begin
      m_held++;
      if (!r[m_cur] || (HOLD != 0 && m_held == HOLD)) begin
        m_active   = 0;
        m_gap_left = GAP;
        m_ptr      = (m_cur + 1) % 8;
      end
    end else begin
      may_pick = 1;
      if (m_gap_left > 0) begin
        m_gap_left--;
        may_pick = (m_gap_left == 0);
      end
      if (may_pick != 0 && e && r != 8'h00) begin
        found = 0;
        for (int k = 0; k < 8; k++) begin
          if (found == 0 && r[(m_ptr + k) % 8]) begin
            m_cur = (m_ptr + k) % 8;
            found = 1;
          end
        end
        m_active = 1;
        m_held   = 0;
      end
    end
  endtask

  // Cross-cycle property trackers.
  logic prev_d;
  logic [2:0] prev_s;
  int low_run;
  int seen_grant;
  logic rose;

  task automatic tracker_reset();
    prev_d = 1'b0; prev_s = 3'd0; low_run = 0; seen_grant = 0; rose = 1'b0;
  endtask

  task automatic tick();
    logic [7:0] exp_gnt;
    @(posedge clk);
    model_step(en, req);
    #1;
    exp_gnt = (m_active != 0) ? (8'd1 << m_cur) : 8'h00;
    check("model_S", S, m_cur);
    check("model_D", D, m_active != 0);
    check("model_gnt", gnt, exp_gnt);
    check("model_busy", busy, (m_active != 0) || (m_gap_left > 0));
    if (prev_d && D) check("s_stable", S, prev_s);
    check("gnt_vs_S", gnt, D ? (8'd1 << S) : 8'h00);
    rose = D && !prev_d;
    if (rose) begin
      if (seen_grant != 0) check("gap_len", low_run >= GAP, 1'b1);
      seen_grant = 1;
      low_run = 0;
    end
    if (!D) low_run++;
    prev_d = D;
    prev_s = S;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_S", S, 3'd0);
    check("rst_D", D, 1'b0);
    check("rst_gnt", gnt, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tracker_reset();
  endtask

  task automatic wait_d(input logic target, input int bound);
    for (int i = 0; i < bound && D !== target; i++) tick();
    check("wait_d", D, target);
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [2:0] s;
    logic       d;
    logic [7:0] gnt;
    logic       busy;
  } vec_t;

  vec_t vecs[15];
  int   order[$];

  initial begin
    // Single sink 5: four-cycle grants separated by one idle cycle.
    for (int k = 0; k < 10; k++) begin
      vecs[k] = '{rst: (k == 0), en: 1'b1, req: 8'h20, s: 3'd5, d: ((k % 5) != 4),
                  gnt: ((k % 5) != 4) ? 8'h20 : 8'h00, busy: 1'b1};
    end
    // Early release: sink 3 drops its request on the third edge after reset.
    vecs[10] = '{rst: 1'b1, en: 1'b1, req: 8'h08, s: 3'd3, d: 1'b1, gnt: 8'h08, busy: 1'b1};
    vecs[11] = '{rst: 1'b0, en: 1'b1, req: 8'h08, s: 3'd3, d: 1'b1, gnt: 8'h08, busy: 1'b1};
    vecs[12] = '{rst: 1'b0, en: 1'b1, req: 8'h00, s: 3'd3, d: 1'b0, gnt: 8'h00, busy: 1'b1};
    vecs[13] = '{rst: 1'b0, en: 1'b1, req: 8'h00, s: 3'd3, d: 1'b0, gnt: 8'h00, busy: 1'b0};
    vecs[14] = '{rst: 1'b0, en: 1'b1, req: 8'h00, s: 3'd3, d: 1'b0, gnt: 8'h00, busy: 1'b0};

    model_reset();
    tracker_reset();

    for (int k = 0; k < 15; k++) begin
      en  = vecs[k].en;
      req = vecs[k].req;
      if (vecs[k].rst) do_reset();
      tick();
      check($sformatf("vec%0d_S", k), S, vecs[k].s);
      check($sformatf("vec%0d_D", k), D, vecs[k].d);
      check($sformatf("vec%0d_gnt", k), gnt, vecs[k].gnt);
      check($sformatf("vec%0d_busy", k), busy, vecs[k].busy);
    end

    // Round robin over all sinks.
    req = 8'hFF; en = 1'b1;
    do_reset();
    for (int i = 0; i < 120 && order.size() < 9; i++) begin
      tick();
      if (rose) order.push_back(int'(S));
    end
    check("rr_count", order.size(), 9);
    for (int k = 0; k < order.size(); k++) check($sformatf("rr_order%0d", k), order[k], k % 8);

    // Asynchronous reset in the middle of a grant.
    wait_d(1'b1, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_D", D, 1'b0);
    check("async_gnt", gnt, 8'h00);
    check("async_S", S, 3'd0);
    check("async_busy", busy, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("held_rst_D", D, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tracker_reset();
    wait_d(1'b1, 5);
    check("post_rst_S", S, 3'd0);

    // Wrap: after sink 6 the pointer sits at 7, so sink 0 beats sink 6.
    req = 8'h40;
    do_reset();
    wait_d(1'b1, 5);
    check("wrap_first", S, 3'd6);
    wait_d(1'b0, 10);
    req = 8'h41;
    wait_d(1'b1, 10);
    check("wrap_to0", S, 3'd0);
    wait_d(1'b0, 10);
    wait_d(1'b1, 10);
    check("wrap_to6", S, 3'd6);

    // en gating: the active grant completes, then the block idles until en returns.
    req = 8'h04;
    do_reset();
    wait_d(1'b1, 5);
    check("gate_S", S, 3'd2);
    en = 1'b0; req = 8'hFF;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) tick();
    check("gate_idle", busy, 1'b0);
    repeat (3) tick();
    check("gate_D_low", D, 1'b0);
    en = 1'b1;
    tick();
    check("gate_resume_D", D, 1'b1);
    check("gate_resume_S", S, 3'd3);

    // No requests: stays idle.
    req = 8'h00;
    do_reset();
    repeat (4) tick();
    check("norq_D", D, 1'b0);
    check("norq_busy", busy, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0)
        req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom) & 8'($urandom);
      en = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
